arbitro_tono: RTL
=================

Name: arbitro_tono

Overview:
- Shares the single tone generator (buzzer driver) between two note sources:
  - the free-play keyboard FSM, which gives a note index and a level "contar";
  - the song sequencer, which gives a note index and duration through a req/ack handshake.
- Free play has priority and preempts song notes.
- Song notes are timed in ticks and followed by a silent gap.
- Sits between both note sources and the tone generator; drives the generator's note select and enable.

Parameters:
- DUR_W, 8, width of the song note duration field, in ticks.
- GAP_TICKS, 2, silent ticks inserted after every completed song note (0 = no gap).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- tick  in  1  one-cycle timing strobe (e.g. 1 ms); all durations count in ticks.
- contar_libre  in  1  free-play source active (level).
- nota_libre  in  3  free-play note index (0 = silence, 1..4 = notes).
- req_cancion  in  1  song sequencer requests a note; held until ack_cancion.
- nota_cancion  in  3  song note index (0 = rest).
- dur_cancion  in  DUR_W  song note duration in ticks.
- ack_cancion  out  1  one-cycle pulse: song request accepted.
- fin_nota  out  1  one-cycle pulse: song note duration expired normally.
- aborto  out  1  one-cycle pulse: song note preempted by free play.
- nota_salida  out  3  note index to the tone generator.
- sonar  out  1  tone generator enable.
- fuente  out  1  0 = free play or idle, 1 = song (CANCION/SILENCIO).
- ocupado  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-note): state IDLE; all outputs 0; duration and gap counters 0.
- States: IDLE, LIBRE, CANCION, SILENCIO.
- IDLE:
  - contar_libre=1 -> LIBRE. Free play wins over a simultaneous req_cancion; no ack is given.
  - else req_cancion=1 -> CANCION:
    - ack_cancion=1 for exactly one cycle (the cycle after the request is sampled);
    - nota_salida=nota_cancion;
    - sonar=(nota_cancion!=0);
    - cnt loaded with dur_cancion, but dur_cancion=0 is loaded as 1.
- LIBRE:
  - each cycle, nota_salida<=nota_libre and sonar<=(nota_libre!=0); one cycle latency.
  - contar_libre=0 -> IDLE, with nota_salida=0 and sonar=0 on the same edge.
  - req_cancion is ignored in LIBRE.
- CANCION:
  - free-play preemption takes precedence over tick. If contar_libre=1 -> LIBRE:
    - aborto=1 for one cycle;
    - no fin_nota;
    - cnt cleared.
  - else on tick with cnt==1:
    - fin_nota=1 for one cycle;
    - nota_salida=0, sonar=0;
    - go to SILENCIO with gap counter=GAP_TICKS, or to IDLE directly if GAP_TICKS=0.
  - else on tick: cnt<=cnt-1.
  - Cycles without tick do not count.
- SILENCIO:
  - nota_salida=0, sonar=0.
  - contar_libre=1 -> LIBRE, no aborto.
  - else on tick: gap-1; when gap reaches 0 -> IDLE.
  - A req_cancion pending during the gap is only accepted from IDLE.
- Timing:
  - Minimum spacing between two ack_cancion pulses is 2 cycles; no back-to-back acks.
  - A new song note is accepted at earliest the cycle after IDLE is re-entered.
- fuente=1 in CANCION and SILENCIO, else 0. ocupado=(state!=IDLE).
- Illegal or unused state encodings recover to IDLE with all outputs 0.
- nota_libre and nota_cancion values 5..7 pass through unmodified.

Test Plan:
- Reset mid-note:
  - stimulus: req_cancion=1, nota_cancion=3, dur=4; assert reset after 2 ticks.
  - required: all outputs 0 immediately (asynchronous); state IDLE; no fin_nota.
- Normal song note:
  - stimulus: from IDLE, req_cancion=1, nota_cancion=2, dur_cancion=3, tick every 10 cycles.
  - required: ack_cancion 1 cycle; nota_salida=2, sonar=1 until the 3rd tick; fin_nota pulse; then 2 ticks of silence with fuente=1; then ocupado=0.
- Simultaneous request:
  - stimulus: contar_libre=1, nota_libre=4 and req_cancion=1 in the same cycle.
  - required: LIBRE; nota_salida=4 next cycle; no ack_cancion while contar_libre holds. After contar_libre=0, the next cycle is IDLE and ack_cancion follows one cycle later.
- Preemption:
  - stimulus: song note 1 with dur=10; after 3 ticks raise contar_libre with nota_libre=3.
  - required: aborto pulse; no fin_nota; nota_salida=3; fuente=0.
- Zero duration and rest:
  - dur_cancion=0 -> behaves as dur=1: fin_nota on the first tick.
  - nota_cancion=0, dur=2 -> sonar=0 for 2 ticks, then fin_nota.
- Tick aligned with preemption:
  - stimulus: tick and contar_libre both asserted on the cycle where cnt==1.
  - required: preemption wins; aborto=1, fin_nota=0.

Source files
------------

// File: rtl/arbitro_tono_if.sv
// rtl/arbitro_tono_if.sv - note sources and tone generator bus for arbitro_tono
// master: the sources/generator side; slave: the arbiter.
interface arbitro_tono_if #(
  parameter int DUR_W = 8
);
  logic             tick;
  logic             contar_libre;
  logic [2:0]       nota_libre;
  logic             req_cancion;
  logic [2:0]       nota_cancion;
  logic [DUR_W-1:0] dur_cancion;
  logic             ack_cancion;
  logic             fin_nota;
  logic             aborto;
  logic [2:0]       nota_salida;
  logic             sonar;
  logic             fuente;
  logic             ocupado;

  modport master (
    output tick, contar_libre, nota_libre, req_cancion, nota_cancion, dur_cancion,
    input  ack_cancion, fin_nota, aborto, nota_salida, sonar, fuente, ocupado
  );

  modport slave (
    input  tick, contar_libre, nota_libre, req_cancion, nota_cancion, dur_cancion,
    output ack_cancion, fin_nota, aborto, nota_salida, sonar, fuente, ocupado
  );
endinterface

// File: rtl/arbitro_tono.sv
// rtl/arbitro_tono.sv - shares one tone generator between free play and the song sequencer
// Free play preempts song notes; song notes are tick-timed and followed by a silent gap.
module arbitro_tono #(
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 2
) (
  input  logic          clk,
  input  logic          reset,
  arbitro_tono_if.slave bus
);
  localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LIBRE    = 2'd1,
    CANCION  = 2'd2,
    SILENCIO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ack_q, ack_d;
  logic             fin_q, fin_d;
  logic             aborto_q, aborto_d;
  logic [2:0]       nota_q, nota_d;
  logic             sonar_q, sonar_d;
  logic             fuente_q, fuente_d;
  logic             ocupado_q, ocupado_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      ack_q     <= 1'b0;
      fin_q     <= 1'b0;
      aborto_q  <= 1'b0;
      nota_q    <= 3'd0;
      sonar_q   <= 1'b0;
      fuente_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      fin_q     <= fin_d;
      aborto_q  <= aborto_d;
      nota_q    <= nota_d;
      sonar_q   <= sonar_d;
      fuente_q  <= fuente_d;
      ocupado_q <= ocupado_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    ack_d    = 1'b0;
    fin_d    = 1'b0;
    aborto_d = 1'b0;
    nota_d   = 3'd0;
    sonar_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.contar_libre) begin
          state_d = LIBRE;
          nota_d  = bus.nota_libre;
          sonar_d = (bus.nota_libre != 3'd0);
        end else if (bus.req_cancion) begin
          state_d = CANCION;
          ack_d   = 1'b1;
          nota_d  = bus.nota_cancion;
          sonar_d = (bus.nota_cancion != 3'd0);
          cnt_d   = (bus.dur_cancion == '0) ? DUR_ONE : bus.dur_cancion;
        end
      end
      LIBRE: begin
        if (bus.contar_libre) begin
          nota_d  = bus.nota_libre;
          sonar_d = (bus.nota_libre != 3'd0);
        end else begin
          state_d = IDLE;
        end
      end
      CANCION: begin
        nota_d  = nota_q;
        sonar_d = sonar_q;
        // Preemption is checked before tick so a last-tick collision still aborts.
        if (bus.contar_libre) begin
          state_d  = LIBRE;
          aborto_d = 1'b1;
          cnt_d    = '0;
          nota_d   = bus.nota_libre;
          sonar_d  = (bus.nota_libre != 3'd0);
        end else if (bus.tick) begin
          if (cnt_q <= DUR_ONE) begin
            fin_d   = 1'b1;
            cnt_d   = '0;
            nota_d  = 3'd0;
            sonar_d = 1'b0;
            if (GAP_TICKS == 0) begin
              state_d = IDLE;
            end else begin
              state_d = SILENCIO;
              gap_d   = GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - DUR_ONE;
          end
        end
      end
      SILENCIO: begin
        if (bus.contar_libre) begin
          state_d = LIBRE;
          gap_d   = '0;
          nota_d  = bus.nota_libre;
          sonar_d = (bus.nota_libre != 3'd0);
        end else if (bus.tick) begin
          if (gap_q <= GAP_ONE) begin
            state_d = IDLE;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - GAP_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
    fuente_d  = (state_d == CANCION) || (state_d == SILENCIO);
    ocupado_d = (state_d != IDLE);
  end

  assign bus.ack_cancion = ack_q;
  assign bus.fin_nota    = fin_q;
  assign bus.aborto      = aborto_q;
  assign bus.nota_salida = nota_q;
  assign bus.sonar       = sonar_q;
  assign bus.fuente      = fuente_q;
  assign bus.ocupado     = ocupado_q;
endmodule
